// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encodings, parity-mode constants, the
// default bit period and a parity helper. Imported by the transmitter, the
// baud-tick counter and (later) the receive side.
package uart_tx_serializer_pkg;

   // 100 MHz clock / 115200 baud
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   // Parity bit for a byte under the given mode; 0 when parity is disabled.
   function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
      if (mode == PARITY_ODD) begin
         return ~^data;
      end else if (mode == PARITY_EVEN) begin
         return ^data;
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake plus line/status signals of the UART transmitter.
//   tx_data  : byte to send, sampled only at acceptance
//   tx_valid : upstream has a byte on tx_data
//   tx_ready : transmitter accepts a byte this cycle
//   tx_busy  : a frame is in progress
//   tx       : serial line, idles high
// master = upstream byte source, slave = transmitter.
interface uart_tx_serializer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_busy,
      input  tx
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_busy,
      output tx
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter shared by the UART transmitter and receiver.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   clear : synchronous clear, holds the count at 0
//   tick  : high for one cycle while the count sits at CLKS_PER_BIT-1
// The count wraps to 0 on the tick, so each period is exactly CLKS_PER_BIT cycles.
module uart_baud_tick
   import uart_tx_serializer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = (cnt_q == CntLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises one byte per frame as start bit, 8 data bits
// LSB first, optional parity bit and 1 or 2 stop bits.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset; line forced high, frame abandoned
//   bus   : slave side of uart_tx_serializer_if (tx_data/tx_valid in,
//           tx_ready/tx_busy/tx out)
// All outputs are registers. CLKS_PER_BIT >= 2, PARITY in {0,1,2},
// STOP_BITS in {1,2}.
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned PARITY       = PARITY_NONE,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_serializer_if.slave bus
);

   localparam bit         HasParity = (PARITY != PARITY_NONE);
   localparam logic [2:0] LastStop  = 3'(STOP_BITS - 1);

   uart_state_e state_q;
   logic [7:0]  shift_q;
   logic [2:0]  bit_idx_q;
   logic        parity_q;
   logic        tx_q;
   logic        ready_q;
   logic        busy_q;

   logic tick;
   logic baud_clear;
   logic accept;

   // Every non-idle state is left exactly on a tick, where the counter wraps
   // to 0 by itself; holding it clear in IDLE makes the start bit begin at 0.
   assign baud_clear = (state_q == StIdle);

   // ready_q is only ever high in IDLE, so this is the full handshake.
   assign accept = bus.tx_valid && ready_q;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .clear(baud_clear),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_idx_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (accept) begin
                  shift_q   <= bus.tx_data;
                  // Parity of the byte as latched; the shift register is consumed.
                  parity_q  <= parity_bit(bus.tx_data, PARITY);
                  bit_idx_q <= '0;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                  state_q   <= StStart;
               end else begin
                  // First edge after reset release raises ready.
                  ready_q <= 1'b1;
               end
            end

            StStart: begin
               if (tick) begin
                  tx_q      <= shift_q[0];
                  bit_idx_q <= '0;
                  state_q   <= StData;
               end
            end

            StData: begin
               if (tick) begin
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_q <= '0;
                     if (HasParity) begin
                        tx_q    <= parity_q;
                        state_q <= StParity;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                     end
                  end else begin
                     shift_q   <= {1'b0, shift_q[7:1]};
                     tx_q      <= shift_q[1];
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end

            StParity: begin
               if (tick) begin
                  tx_q      <= 1'b1;
                  bit_idx_q <= '0;
                  state_q   <= StStop;
               end
            end

            StStop: begin
               // bit_idx_q counts whole stop-bit periods here.
               if (tick) begin
                  if (bit_idx_q == LastStop) begin
                     bit_idx_q <= '0;
                     busy_q    <= 1'b0;
                     ready_q   <= 1'b1;
                     state_q   <= StIdle;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end

            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_ready = ready_q;
   assign bus.tx_busy  = busy_q;

endmodule
